// File: rtl/cpu_pkg.sv
// Shared CPU definitions: RoB tag width, no-dependency marker,
// CDB payload layout and CDB source ids.
package cpu_pkg;

  localparam int RoB_WIDTH = 3;

  // Operand tag value meaning "no producer pending".
  localparam logic [RoB_WIDTH:0] NON_DEP = {1'b1, {RoB_WIDTH{1'b0}}};

  localparam logic CDB_SRC_ALU = 1'b0;
  localparam logic CDB_SRC_LSB = 1'b1;

  typedef struct packed {
    logic [RoB_WIDTH-1:0] rob_idx;
    logic [31:0]          value;
    logic [31:0]          next_pc;
    logic                 taken;
    logic                 src;
  } cdb_pkt_t;

endpackage

// File: rtl/cdb_src_fifo.sv
// Small per-source result FIFO for the CDB arbiter.
// Ports: clk_in/rst_in, push/pop/clear, din, head data, full/empty.
module cdb_src_fifo #(
  parameter int WIDTH = 68,
  parameter int AW    = 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  import cpu_pkg::*;

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [AW:0]      count_q, count_d;

  assign head  = mem_q[head_q];
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[tail_q] = din;
        tail_d        = tail_q + AW'(1);
      end
      if (pop) begin
        head_d = head_q + AW'(1);
      end
      count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the registered CDB between ALU and LSB.
// Ports: ALU/LSB result inputs with ready, cdb_* broadcast outputs.
// Macro CDB_PERF_CNT_EN adds perf_conflict/perf_stall counters.
module cdb_arbiter #(
  parameter int RoB_WIDTH = cpu_pkg::RoB_WIDTH,
  parameter int BUF_AW    = 1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush_in,
  input  logic                 alu_valid,
  input  logic [RoB_WIDTH-1:0] alu_rob_idx,
  input  logic [31:0]          alu_value,
  input  logic [31:0]          alu_next_pc,
  input  logic                 alu_taken,
  output logic                 alu_ready,
  input  logic                 lsb_valid,
  input  logic [RoB_WIDTH-1:0] lsb_rob_idx,
  input  logic [31:0]          lsb_value,
  output logic                 lsb_ready,
  output logic                 cdb_valid,
  output logic [RoB_WIDTH-1:0] cdb_rob_idx,
  output logic [31:0]          cdb_value,
  output logic [31:0]          cdb_next_pc,
  output logic                 cdb_taken,
  output logic                 cdb_src
`ifdef CDB_PERF_CNT_EN
  ,
  output logic [31:0]          perf_conflict,
  output logic [31:0]          perf_stall
`endif
);
  import cpu_pkg::*;

  // Payload: {rob_idx, value, next_pc, taken}
  localparam int PW = RoB_WIDTH + 65;

  logic          act;
  logic          a_full, a_empty, l_full, l_empty;
  logic          a_push, l_push, a_pop, l_pop;
  logic [PW-1:0] a_din, l_din, a_head, l_head;

  logic          rr_q, rr_d;
  logic          cdb_valid_q, cdb_valid_d;
  logic [PW-1:0] cdb_pkt_q, cdb_pkt_d;
  logic          cdb_src_q, cdb_src_d;

  assign act       = rdy_in && !flush_in;
  assign alu_ready = !a_full && act;
  assign lsb_ready = !l_full && act;
  assign a_push    = alu_valid && alu_ready;
  assign l_push    = lsb_valid && lsb_ready;
  assign a_din     = {alu_rob_idx, alu_value, alu_next_pc, alu_taken};
  assign l_din     = {lsb_rob_idx, lsb_value, 32'h0, 1'b0};

  cdb_src_fifo #(.WIDTH(PW), .AW(BUF_AW)) u_alu_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (a_push),
    .pop    (a_pop),
    .clear  (flush_in),
    .din    (a_din),
    .head   (a_head),
    .full   (a_full),
    .empty  (a_empty)
  );

  cdb_src_fifo #(.WIDTH(PW), .AW(BUF_AW)) u_lsb_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (l_push),
    .pop    (l_pop),
    .clear  (flush_in),
    .din    (l_din),
    .head   (l_head),
    .full   (l_full),
    .empty  (l_empty)
  );

  // rr_q names the source that wins the next contention only.
  always_comb begin
    a_pop = 1'b0;
    l_pop = 1'b0;
    rr_d  = rr_q;
    if (flush_in) begin
      rr_d = 1'b0;
    end else if (rdy_in) begin
      if (!a_empty && !l_empty) begin
        a_pop = (rr_q == CDB_SRC_ALU);
        l_pop = (rr_q == CDB_SRC_LSB);
        rr_d  = ~rr_q;
      end else begin
        a_pop = !a_empty;
        l_pop = !l_empty;
      end
    end
  end

  always_comb begin
    cdb_valid_d = cdb_valid_q;
    cdb_pkt_d   = cdb_pkt_q;
    cdb_src_d   = cdb_src_q;
    if (flush_in) begin
      cdb_valid_d = 1'b0;
    end else if (rdy_in) begin
      cdb_valid_d = a_pop || l_pop;
      if (a_pop) begin
        cdb_pkt_d = a_head;
        cdb_src_d = CDB_SRC_ALU;
      end else if (l_pop) begin
        cdb_pkt_d = l_head;
        cdb_src_d = CDB_SRC_LSB;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rr_q        <= 1'b0;
      cdb_valid_q <= 1'b0;
      cdb_pkt_q   <= '0;
      cdb_src_q   <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_pkt_q   <= cdb_pkt_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  assign cdb_valid   = cdb_valid_q;
  assign cdb_rob_idx = cdb_pkt_q[PW-1:65];
  assign cdb_value   = cdb_pkt_q[64:33];
  assign cdb_next_pc = cdb_pkt_q[32:1];
  assign cdb_taken   = cdb_pkt_q[0];
  assign cdb_src     = cdb_src_q;

`ifdef CDB_PERF_CNT_EN
  logic [31:0] conf_q, conf_d;
  logic [31:0] stall_q, stall_d;

  // Not cleared by flush; free-running wrap.
  always_comb begin
    conf_d  = conf_q;
    stall_d = stall_q;
    if (!a_empty && !l_empty && rdy_in) begin
      conf_d = conf_q + 32'd1;
    end
    if ((alu_valid && !alu_ready) || (lsb_valid && !lsb_ready)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      conf_q  <= '0;
      stall_q <= '0;
    end else begin
      conf_q  <= conf_d;
      stall_q <= stall_d;
    end
  end

  assign perf_conflict = conf_q;
  assign perf_stall    = stall_q;
`endif

  // Producers must not offer a result the FIFO cannot take.
  always @(posedge clk_in) begin
    if (!rst_in) begin
      assert (!(alu_valid && !alu_ready))
        else $error("alu_valid asserted while alu_ready low");
      assert (!(lsb_valid && !lsb_ready))
        else $error("lsb_valid asserted while lsb_ready low");
    end
  end

endmodule
